// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the control unit (master) and the multicycle ALU (slave).
// Operands and op travel with in_valid/in_ready; result and flags travel with out_valid/out_ready.
interface multicycle_alu_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             alusrc;
  logic [WIDTH-1:0] readdata1;
  logic [WIDTH-1:0] readdata2;
  logic [WIDTH-1:0] sign_extended;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, op, alusrc, readdata1, readdata2, sign_extended, out_ready,
    input  in_ready, out_valid, out, zero, carry, overflow
  );

  modport slave (
    input  in_valid, op, alusrc, readdata1, readdata2, sign_extended, out_ready,
    output in_ready, out_valid, out, zero, carry, overflow
  );
endinterface

// File: rtl/multicycle_alu.sv
// Registered ALU with status flags and a WIDTH-step shift-add multiplier.
// Single-cycle ops finish on the accept edge; MUL spends WIDTH cycles in the MUL state.
module multicycle_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_alu_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SLT = 3'b101, OP_SLL = 3'b110, OP_MUL = 3'b111
  } op_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   a, b_sel, alu_res;
  logic [WIDTH:0]     sum, diff;
  logic               alu_carry, alu_ovf;
  logic [2*WIDTH-1:0] acc_step;

  // Single-cycle result path, evaluated straight from the bus in the accept cycle.
  always_comb begin
    a         = bus.readdata1;
    b_sel     = bus.alusrc ? bus.sign_extended : bus.readdata2;
    sum       = {1'b0, a} + {1'b0, b_sel};
    diff      = {1'b0, a} - {1'b0, b_sel};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op_e'(bus.op))
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b_sel[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b_sel;
      OP_OR:  alu_res = a | b_sel;
      OP_XOR: alu_res = a ^ b_sel;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b_sel))};
      // Shift amounts of WIDTH or more push every bit out.
      OP_SLL: alu_res = (|b_sel[WIDTH-1:SHW]) ? '0 : (a << b_sel[SHW-1:0]);
      default: ;
    endcase
  end

  // The multiplicand register is pre-shifted each step, so it always sits at the current bit weight.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (op_e'(bus.op) == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b_sel;
            acc_d    = '0;
            cnt_d    = (SHW+1)'(WIDTH);
            state_d  = S_MUL;
          end else begin
            out_d   = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
            ovf_d   = alu_ovf;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == (SHW+1)'(1)) begin
          out_d   = acc_step[WIDTH-1:0];
          zero_d  = (acc_step[WIDTH-1:0] == '0);
          carry_d = 1'b0;
          ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset abandons any in-flight multiply and clears the visible result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

endmodule
